// File: rtl/matrix_axi_lite_initiator_if.sv
// rtl/matrix_axi_lite_initiator_if.sv - AXI-Lite master/slave bus bundle
interface matrix_axi_lite_initiator_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/matrix_axi_lite_initiator.sv
// rtl/matrix_axi_lite_initiator.sv - single-outstanding AXI-Lite initiator with command/response ports
module matrix_axi_lite_initiator #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_we,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  matrix_axi_lite_initiator_if.master axi,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        txn_cnt,
  output logic [CNT_WIDTH-1:0]        err_cnt
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic                      we_q, we_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_we_q, rsp_we_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic [CNT_WIDTH-1:0]      txn_cnt_q, txn_cnt_d;
  logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
  logic                      aw_done, w_done;

  // Next-state and registered-output computation; every output is a flop so
  // nothing on the bus or response side depends combinationally on an input.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    we_d        = we_q;
    cmd_ready_d = cmd_ready_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;
    // A channel counts as done if it already handshook or handshakes now.
    aw_done     = !aw_valid_q || axi.aw_ready;
    w_done      = !w_valid_q || axi.w_ready;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          strb_d      = cmd_strb;
          we_d        = cmd_we;
          cmd_ready_d = 1'b0;
          if (cmd_we) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_valid_q && axi.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && axi.w_ready) w_valid_d = 1'b0;
        if (aw_done && w_done) begin
          b_ready_d = 1'b1;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi.b_valid && b_ready_q) begin
          rsp_resp_d  = axi.b_resp;
          rsp_rdata_d = '0;
          rsp_we_d    = we_q;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (axi.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi.r_valid && r_ready_q) begin
          rsp_rdata_d = axi.r_data;
          rsp_resp_d  = axi.r_resp;
          rsp_we_d    = we_q;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          txn_cnt_d   = txn_cnt_q + 1'b1;
          if (rsp_resp_q != 2'b00) err_cnt_d = err_cnt_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_we       = rsp_we_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign busy         = (state_q != IDLE);
  assign txn_cnt      = txn_cnt_q;
  assign err_cnt      = err_cnt_q;

  assign axi.aw_addr  = addr_q;
  assign axi.aw_prot  = 3'b000;
  assign axi.aw_valid = aw_valid_q;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = strb_q;
  assign axi.w_valid  = w_valid_q;
  assign axi.b_ready  = b_ready_q;
  assign axi.ar_addr  = addr_q;
  assign axi.ar_prot  = 3'b000;
  assign axi.ar_valid = ar_valid_q;
  assign axi.r_ready  = r_ready_q;
endmodule

// File: tb/tb_matrix_axi_lite_initiator.sv
// tb/tb_matrix_axi_lite_initiator.sv - self-checking bench for matrix_axi_lite_initiator
module tb_matrix_axi_lite_initiator;
  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_we, rsp_ready;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        cmd_ready, rsp_valid, rsp_we, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] txn_cnt, err_cnt;
  logic        cmd_ready4, rsp_valid4, rsp_we4, busy4;
  logic [31:0] rsp_rdata4;
  logic [1:0]  rsp_resp4;
  logic [3:0]  txn_cnt4, err_cnt4;

  matrix_axi_lite_initiator_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32)) bus ();
  matrix_axi_lite_initiator_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32)) bus4 ();

  matrix_axi_lite_initiator #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(bus),
    .busy(busy), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter copy driven in lockstep with the main instance.
  matrix_axi_lite_initiator #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_we(rsp_we4),
    .rsp_rdata(rsp_rdata4), .rsp_resp(rsp_resp4),
    .axi(bus4),
    .busy(busy4), .txn_cnt(txn_cnt4), .err_cnt(err_cnt4)
  );

  assign bus4.aw_ready = bus.aw_ready;
  assign bus4.w_ready  = bus.w_ready;
  assign bus4.b_resp   = bus.b_resp;
  assign bus4.b_valid  = bus.b_valid;
  assign bus4.ar_ready = bus.ar_ready;
  assign bus4.r_data   = bus.r_data;
  assign bus4.r_resp   = bus.r_resp;
  assign bus4.r_valid  = bus.r_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[6];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_txn = '0;
  logic [15:0] exp_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave();
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    bus.r_valid = 1'b0; bus.r_resp = 2'b00; bus.r_data = '0;
  endtask

  // Present a command and wait for acceptance; returns at posedge+1 of T+1.
  task automatic issue(input vec_t v);
    logic ok;
    tick();
    cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", ok, 1'b1);
  endtask

  // Ready slave: checks bus contents at T+1, then waits for rsp_valid.
  task automatic serve(input vec_t v);
    logic got;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.ar_ready = 1'b1;
    if (v.we) begin
      bus.b_valid = 1'b1; bus.b_resp = v.slv_resp;
    end else begin
      bus.r_valid = 1'b1; bus.r_resp = v.slv_resp; bus.r_data = v.slv_rdata;
    end
    @(negedge clk);
    if (v.we) begin
      check("aw_valid", bus.aw_valid, 1'b1);
      check("aw_addr", bus.aw_addr, v.addr);
      check("w_data", {bus.w_valid, bus.w_strb, bus.w_data}, {1'b1, v.strb, v.wdata});
      check("b_ready_early", bus.b_ready, 1'b0);
      check("aw_prot", bus.aw_prot, 3'b000);
    end else begin
      check("ar_valid", bus.ar_valid, 1'b1);
      check("ar_addr", bus.ar_addr, v.addr);
      check("ar_prot", bus.ar_prot, 3'b000);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check("rsp_valid_seen", got, 1'b1);
    check("rsp_we", rsp_we, v.exp_we);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_resp", rsp_resp, v.exp_resp);
  endtask

  // Complete the response handshake and compare counters with the model.
  task automatic rsp_handshake(input logic [1:0] resp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    clear_slave();
    exp_txn = exp_txn + 16'd1;
    if (resp != 2'b00) exp_err = exp_err + 16'd1;
    @(negedge clk);
    check("txn_cnt", txn_cnt, exp_txn);
    check("err_cnt", err_cnt, exp_err);
    check("txn_cnt_w4", txn_cnt4, exp_txn[3:0]);
    check("idle_after_rsp", {cmd_ready, busy, rsp_valid}, 3'b100);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    serve(v);
    rsp_handshake(v.exp_resp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 64'h0000_0000_4000_0100, 32'hDEADBEEF, 4'hF, 32'h0BAD0BAD, 2'b00, 32'h0,        2'b00, 1'b1};
    vecs[1] = '{1'b0, 64'h0000_0000_5000_0004, 32'h0,        4'h0, 32'h12345678, 2'b10, 32'h12345678, 2'b10, 1'b0};
    vecs[2] = '{1'b1, 64'h0000_0000_0000_0010, 32'hA5A5A5A5, 4'h3, 32'hFFFFFFFF, 2'b11, 32'h0,        2'b11, 1'b1};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_0020, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D, 2'b00, 1'b0};
    vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0,        4'h0, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 2'b01, 1'b0};
    vecs[5] = '{1'b1, 64'h0000_0000_0000_0000, 32'h0,        4'h0, 32'h00000055, 2'b00, 32'h0,        2'b00, 1'b1};

    // Reset state
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0;
    clear_slave();
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rsp_valid}, 6'b0);
    check("rst_rsp", {rsp_we, rsp_resp, rsp_rdata}, 35'b0);
    check("rst_cnts", {txn_cnt, err_cnt}, 32'b0);

    // Write with both channels ready, b_valid two cycles after AW/W
    tick();
    cmd_we = 1'b1; cmd_addr = 64'h4000_0000; cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b_t1_valids", {bus.aw_valid, bus.w_valid, busy, cmd_ready}, 4'b1110);
    tick();
    @(negedge clk);
    check("b_t2", {bus.aw_valid, bus.w_valid, bus.b_ready}, 3'b001);
    tick();
    bus.b_valid = 1'b1; bus.b_resp = 2'b00;
    @(negedge clk);
    check("b_t3", {bus.b_ready, rsp_valid}, 2'b10);
    tick();
    bus.b_valid = 1'b0;
    @(negedge clk);
    check("b_rsp", {rsp_valid, rsp_we, rsp_resp, bus.b_ready}, 5'b11000);
    check("b_rdata", rsp_rdata, 32'h0);
    rsp_handshake(2'b00);

    // Write with W accepted at T+1 and AW delayed to T+5
    tick();
    cmd_we = 1'b1; cmd_addr = 64'h40; cmd_wdata = 32'h11223344; cmd_strb = 4'hC;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("c_t1", {bus.aw_valid, bus.w_valid}, 2'b11);
    tick();
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("c_hold_t%0d", k), {bus.w_valid, bus.aw_valid, bus.b_ready, bus.aw_addr}, {3'b010, 64'h40});
      tick();
    end
    bus.aw_ready = 1'b1;
    @(negedge clk);
    check("c_t5", {bus.aw_valid, bus.b_ready}, 2'b10);
    tick();
    bus.aw_ready = 1'b0;
    @(negedge clk);
    check("c_t6", {bus.aw_valid, bus.b_ready}, 2'b01);
    bus.b_valid = 1'b1; bus.b_resp = 2'b01;
    tick();
    bus.b_valid = 1'b0;
    @(negedge clk);
    check("c_rsp", {rsp_valid, rsp_we, rsp_resp}, 4'b1101);
    rsp_handshake(2'b01);

    // Table of directed transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Response back-pressure with a queued command
    issue(vecs[3]);
    serve(vecs[3]);
    cmd_we = vecs[2].we; cmd_addr = vecs[2].addr; cmd_wdata = vecs[2].wdata; cmd_strb = vecs[2].strb;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("d_hold_%0d", k),
            {rsp_valid, rsp_we, rsp_resp, rsp_rdata, cmd_ready, busy},
            {1'b1, 1'b0, 2'b00, 32'hCAFEF00D, 1'b0, 1'b1});
    end
    rsp_handshake(2'b00);
    tick();
    cmd_valid = 1'b0;
    serve(vecs[2]);
    rsp_handshake(vecs[2].exp_resp);

    // Reset asserted while waiting in WR_RESP
    issue(vecs[0]);
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("e_in_wr_resp", bus.b_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_txn = '0; exp_err = '0;
    check("e_rst_valids", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready, rsp_valid}, 6'b0);
    check("e_rst_cnts", {txn_cnt, err_cnt, txn_cnt4}, 36'b0);
    check("e_rst_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_slave();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("e_no_rsp_%0d", k), {cmd_ready, rsp_valid, busy}, 3'b100);
    end
    run_vec(vecs[1]);

    // Fifteen more transactions: sixteen since reset wraps the 4-bit counter
    for (int i = 0; i < 15; i++) run_vec(vecs[i % 6]);
    check("wrap_w4", txn_cnt4, 4'd0);
    check("no_wrap_w16", txn_cnt, 16'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/matrix_axi_lite_initiator.md
MATRIX_AXI_LITE_INITIATOR -- requirements
Module: matrix_axi_lite_initiator

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, AXI-Lite address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI-Lite data width; strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 SHALL provide one clock and an asynchronous active-low reset, named as in the codebase: clk input 1 (clock); rst_n input 1 (reset).
REQ-005 SHALL have command ports: cmd_valid input 1; cmd_ready output 1; cmd_we input 1 (1 = write, 0 = read); cmd_addr input AXI_ADDR_WIDTH; cmd_wdata input AXI_DATA_WIDTH; cmd_strb input AXI_DATA_WIDTH/8.
REQ-006 SHALL have response ports: rsp_valid output 1; rsp_ready input 1; rsp_we output 1; rsp_rdata output AXI_DATA_WIDTH; rsp_resp output 2.
REQ-007 SHALL have AXI-Lite master ports: aw_addr/aw_prot/aw_valid out, aw_ready in; w_data/w_strb/w_valid out, w_ready in; b_resp/b_valid in, b_ready out; ar_addr/ar_prot/ar_valid out, ar_ready in; r_data/r_resp/r_valid in, r_ready out. aw_prot and ar_prot SHALL be tied to 3'b000.
REQ-008 SHALL have status ports: busy output 1; txn_cnt output CNT_WIDTH; err_cnt output CNT_WIDTH.

Function
REQ-009 SHALL implement the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-010 cmd_ready SHALL be 1 only in IDLE. A command is accepted when cmd_valid & cmd_ready.
- Accepting a command SHALL register addr, wdata, strb and we.
- Next state is WR_REQ if cmd_we, else RD_REQ.
REQ-011 SHALL source every AXI valid/ready output and every rsp_* output from a flop; no combinational path from any input to any output.
REQ-012 Write, command accepted at cycle T: aw_valid and w_valid SHALL both be 1 from T+1.
- Each SHALL drop the cycle after its own handshake; AW and W complete independently, in either order or in the same cycle.
REQ-013 Once both AW and W have handshaken, the block SHALL enter WR_RESP with b_ready=1 in the following cycle.
REQ-014 On b_valid & b_ready:
- b_resp SHALL be captured into rsp_resp.
- rsp_rdata SHALL be 0 and rsp_we SHALL be 1.
- b_ready SHALL drop and the block SHALL enter RSP, with rsp_valid=1 in the next cycle.
REQ-015 Read, command accepted at cycle T: ar_valid SHALL be 1 from T+1 until the ar handshake.
- After the ar handshake the block SHALL enter RD_RESP with r_ready=1.
- On r handshake, r_data and r_resp SHALL be captured, rsp_we SHALL be 0, and the block SHALL enter RSP.
REQ-016 In RSP, rsp_valid SHALL stay 1 with all rsp_* stable until rsp_ready=1; the block then returns to IDLE and cmd_ready is 1 the next cycle.
REQ-017 Exactly one transaction SHALL be outstanding; AXI valids SHALL never be withdrawn before handshake, and address/data SHALL stay stable while valid.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 txn_cnt SHALL increment by 1 on each rsp handshake.
REQ-020 err_cnt SHALL increment on each rsp handshake with rsp_resp != 2'b00.
REQ-021 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-022 b_valid or r_valid arriving outside the corresponding *_RESP state SHALL be ignored, since the matching ready is 0.

Reset
REQ-023 On rst_n=0, asynchronously:
- state SHALL be IDLE.
- All valid and ready outputs SHALL be 0, except cmd_ready=1 after reset release.
- rsp_rdata, rsp_resp, rsp_we, txn_cnt and err_cnt SHALL be 0.
- busy SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no response generated; counters SHALL clear.

Verification
REQ-025 Write 0xDEADBEEF to 0x4000_0000, strb 0xF, aw_ready=w_ready=1, b_valid 2 cycles later with OKAY -> rsp_valid, rsp_we=1, rsp_resp=00, txn_cnt=1.
REQ-026 Write with w_ready=1 at T+1 and aw_ready delayed to T+5 -> w_valid drops at T+2, aw_valid held stable to T+5, and b_ready rises only after the aw handshake.
REQ-027 Read 0x5000_0004, slave returns r_data=0x12345678 with r_resp=SLVERR -> rsp_rdata=0x12345678, rsp_resp=10, err_cnt=1.
REQ-028 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_* stable, cmd_ready=0, and a new cmd_valid is not accepted until one cycle after rsp_ready.
REQ-029 Assert rst_n=0 while in WR_RESP -> all valids/readies 0 immediately and txn_cnt=0; a read after release completes normally.
REQ-030 Counter wrap: with CNT_WIDTH=4, 16 transactions -> txn_cnt returns to 0.
